// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices for the control vectors and the
// mul/div sequencer state encoding.
package pipe_pkg;

   localparam int ST_IF    = 0;
   localparam int ST_ID    = 1;
   localparam int ST_EX    = 2;
   localparam int ST_MEM   = 3;
   localparam int ST_WB    = 4;
   localparam int N_STAGES = 5;

   typedef enum logic {
      IDLE,
      BUSY
   } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the control vectors returned to it.
// The pipeline side is the master and the hazard controller is the slave.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import pipe_pkg::*;

   logic [4:0]          id_rs;
   logic [4:0]          id_rt;
   logic                id_use_rs;
   logic                id_use_rt;
   logic [4:0]          ex_rd;
   logic                ex_load;
   logic                ex_branch_taken;
   logic                ex_md_start;
   logic                ex_md_div;
   logic                mem_req;
   logic                mem_ready;
   logic [N_STAGES-1:0] stall;
   logic [N_STAGES-1:0] flush;
   logic [N_STAGES-1:0] extend;
   logic                md_done;
   logic                mem_err;
   logic [CNT_W-1:0]    stall_cycles;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load,
             ex_branch_taken, ex_md_start, ex_md_div, mem_req, mem_ready,
      input  stall, flush, extend, md_done, mem_err, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load,
             ex_branch_taken, ex_md_start, ex_md_div, mem_req, mem_ready,
      output stall, flush, extend, md_done, mem_err, stall_cycles
   );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mul/div occupancy sequencer: holds EX for the op's full latency and pulses
// md_done in the final cycle, when EX is released.
module md_sequencer
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic is_div,
   output logic busy_extend,
   output logic md_done
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   md_state_e       state;
   logic [CW-1:0]   cnt;

   // The start cycle itself counts as the first occupancy cycle, so the
   // counter is loaded with latency-1 and the op is done when it reaches 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_extend = ((state == IDLE) && start) || ((state == BUSY) && (cnt > CW'(1)));
   assign md_done     = (state == BUSY) && (cnt == CW'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritises memory wait, mul/div occupancy,
// taken branches and load-use into stall/flush/extend, plus watchdog and counter.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES  = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   logic [WW-1:0]       wcnt;
   logic [CNT_W-1:0]    stall_cnt;
   logic                waiting;
   logic                fire;
   logic                mem_wait;
   logic                load_use;
   logic                busy_extend;
   logic                md_done_raw;
   logic [N_STAGES-1:0] stall_v;
   logic [N_STAGES-1:0] flush_v;
   logic [N_STAGES-1:0] extend_v;

   assign waiting  = bus.mem_req && !bus.mem_ready;
   assign fire     = waiting && (wcnt == WW'(MEM_TIMEOUT));
   assign mem_wait = waiting && !fire;
   assign load_use = bus.ex_load && (bus.ex_rd != 5'd0) &&
                     ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                      (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

   // A mul/div cannot start while MEM is stalled; it is picked up once the wait ends.
   md_sequencer #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md (
      .clk         (clk),
      .rst         (rst),
      .start       (bus.ex_md_start && !mem_wait),
      .is_div      (bus.ex_md_div),
      .busy_extend (busy_extend),
      .md_done     (md_done_raw)
   );

   always_comb begin
      stall_v  = '0;
      flush_v  = '0;
      extend_v = '0;
      if (mem_wait) begin
         extend_v[ST_MEM] = 1'b1;
      end else if (busy_extend) begin
         extend_v[ST_EX] = 1'b1;
      end else if (bus.ex_branch_taken) begin
         flush_v[ST_ID] = 1'b1;
      end else if (load_use) begin
         stall_v[ST_ID] = 1'b1;
      end
      if (fire) begin
         flush_v[ST_MEM] = 1'b1;
      end
   end

   // The watchdog restarts after firing so a still-stuck access is flushed again later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt <= '0;
      end else if (!waiting || fire) begin
         wcnt <= '0;
      end else begin
         wcnt <= wcnt + WW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((|(stall_v | extend_v)) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Outputs are combinational, so they are masked while reset is held.
   assign bus.stall        = rst ? '0 : stall_v;
   assign bus.flush        = rst ? '0 : flush_v;
   assign bus.extend       = rst ? '0 : extend_v;
   assign bus.md_done      = !rst && md_done_raw;
   assign bus.mem_err      = !rst && fire;
   assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against an occupancy/wait-length reference model.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   localparam int MUL_C = 4;
   localparam int DIV_C = 32;
   localparam int TMO   = 64;
   localparam int CW    = 8;
   localparam int CMAX  = (1 << CW) - 1;

   typedef struct packed {
      logic       rst;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_use_rs;
      logic       id_use_rt;
      logic [4:0] ex_rd;
      logic       ex_load;
      logic       ex_branch_taken;
      logic       ex_md_start;
      logic       ex_md_div;
      logic       mem_req;
      logic       mem_ready;
   } stim_t;

   logic clk = 1'b0;
   logic rst;

   hazard_ctrl_if #(.CNT_W(CW)) bus ();

   hazard_ctrl #(
      .MUL_CYCLES  (MUL_C),
      .DIV_CYCLES  (DIV_C),
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks    = 0;
   int n_fail      = 0;
   int md_left     = 0;
   int wait_run    = 0;
   int stall_count = 0;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      s.mem_ready = 1'b1;
      return s;
   endfunction

   // One cycle: drive at the falling edge, check just after, then advance the model.
   task automatic apply_stimulus(input stim_t s);
      int         occ;
      logic       waiting, fire, mwait, lu;
      logic [4:0] e_stall, e_flush, e_ext;
      logic       e_done, e_err;
      @(negedge clk);
      rst                 = s.rst;
      bus.id_rs           = s.id_rs;
      bus.id_rt           = s.id_rt;
      bus.id_use_rs       = s.id_use_rs;
      bus.id_use_rt       = s.id_use_rt;
      bus.ex_rd           = s.ex_rd;
      bus.ex_load         = s.ex_load;
      bus.ex_branch_taken = s.ex_branch_taken;
      bus.ex_md_start     = s.ex_md_start;
      bus.ex_md_div       = s.ex_md_div;
      bus.mem_req         = s.mem_req;
      bus.mem_ready       = s.mem_ready;
      #1;
      e_stall = '0;
      e_flush = '0;
      e_ext   = '0;
      e_done  = 1'b0;
      e_err   = 1'b0;
      occ     = 0;
      waiting = 1'b0;
      fire    = 1'b0;
      if (s.rst) begin
         md_left     = 0;
         wait_run    = 0;
         stall_count = 0;
      end else begin
         waiting = s.mem_req && !s.mem_ready;
         fire    = waiting && (wait_run == TMO);
         mwait   = waiting && !fire;
         occ     = md_left;
         if (md_left == 0 && s.ex_md_start && !mwait) occ = s.ex_md_div ? DIV_C : MUL_C;
         e_done = (occ == 1);
         lu = s.ex_load && (s.ex_rd != 0) &&
              ((s.id_use_rs && s.id_rs == s.ex_rd) || (s.id_use_rt && s.id_rt == s.ex_rd));
         if (mwait)                  e_ext[3]   = 1'b1;
         else if (occ > 1)           e_ext[2]   = 1'b1;
         else if (s.ex_branch_taken) e_flush[1] = 1'b1;
         else if (lu)                e_stall[1] = 1'b1;
         if (fire) e_flush[3] = 1'b1;
         e_err = fire;
      end
      check_output("stall", 32'(bus.stall), 32'(e_stall));
      check_output("flush", 32'(bus.flush), 32'(e_flush));
      check_output("extend", 32'(bus.extend), 32'(e_ext));
      check_output("md_done", 32'(bus.md_done), 32'(e_done));
      check_output("mem_err", 32'(bus.mem_err), 32'(e_err));
      check_output("stall_cycles", 32'(bus.stall_cycles), 32'(stall_count));
      if (!s.rst) begin
         md_left  = (occ > 0) ? occ - 1 : 0;
         wait_run = (waiting && !fire) ? wait_run + 1 : 0;
         if ((e_stall | e_ext) != 5'd0 && stall_count < CMAX) stall_count++;
      end
   endtask

   initial begin
      stim_t s;
      int    burst;

      // Reset held with every hazard active: everything must stay low.
      s = quiet();
      s.rst = 1'b1; s.ex_load = 1'b1; s.ex_rd = 5'd5; s.id_rs = 5'd5; s.id_use_rs = 1'b1;
      s.ex_md_start = 1'b1; s.ex_branch_taken = 1'b1; s.mem_req = 1'b1; s.mem_ready = 1'b0;
      apply_stimulus(s);
      apply_stimulus(s);
      apply_stimulus(quiet());

      // Load-use on rs, then the load leaves EX; r0 never hazards; rt path.
      s = quiet(); s.ex_load = 1'b1; s.ex_rd = 5'd5; s.id_rs = 5'd5; s.id_use_rs = 1'b1;
      apply_stimulus(s);
      apply_stimulus(quiet());
      s.ex_rd = 5'd0; s.id_rs = 5'd0;
      apply_stimulus(s);
      s = quiet(); s.ex_load = 1'b1; s.ex_rd = 5'd9; s.id_rt = 5'd9; s.id_use_rt = 1'b1;
      apply_stimulus(s);
      s.id_use_rt = 1'b0;
      apply_stimulus(s);

      // Branch together with load-use: flush only.
      s = quiet(); s.ex_load = 1'b1; s.ex_rd = 5'd5; s.id_rs = 5'd5; s.id_use_rs = 1'b1;
      s.ex_branch_taken = 1'b1;
      apply_stimulus(s);

      // Multiply held in EX for its full latency.
      for (int i = 0; i < MUL_C; i++) begin
         s = quiet(); s.ex_md_start = 1'b1;
         apply_stimulus(s);
      end
      apply_stimulus(quiet());

      // Divide with a 5-cycle memory wait starting at cycle 10.
      for (int i = 0; i < DIV_C; i++) begin
         s = quiet(); s.ex_md_start = 1'b1; s.ex_md_div = 1'b1;
         if (i >= 10 && i < 15) begin s.mem_req = 1'b1; s.mem_ready = 1'b0; end
         apply_stimulus(s);
      end
      apply_stimulus(quiet());

      // Watchdog fires, then a completion that lands exactly on the timeout.
      for (int i = 0; i <= TMO; i++) begin
         s = quiet(); s.mem_req = 1'b1; s.mem_ready = 1'b0;
         apply_stimulus(s);
      end
      s = quiet(); s.mem_req = 1'b1;
      apply_stimulus(s);
      for (int i = 0; i <= TMO; i++) begin
         s = quiet(); s.mem_req = 1'b1; s.mem_ready = (i == TMO);
         apply_stimulus(s);
      end

      // Reset in the middle of a divide.
      for (int i = 0; i < 12; i++) begin
         s = quiet(); s.ex_md_start = 1'b1; s.ex_md_div = 1'b1;
         apply_stimulus(s);
      end
      s.rst = 1'b1;
      apply_stimulus(s);
      apply_stimulus(quiet());
      apply_stimulus(quiet());

      // Random traffic with bursts of long memory waits and rare resets.
      burst = 0;
      for (int c = 0; c < 3000; c++) begin
         s = quiet();
         s.ex_rd           = 5'($urandom_range(0, 7));
         s.id_rs           = 5'($urandom_range(0, 7));
         s.id_rt           = 5'($urandom_range(0, 7));
         s.id_use_rs       = ($urandom_range(0, 1) == 1);
         s.id_use_rt       = ($urandom_range(0, 1) == 1);
         s.ex_load         = ($urandom_range(0, 2) == 0);
         s.ex_branch_taken = ($urandom_range(0, 5) == 0);
         s.ex_md_start     = ($urandom_range(0, 7) == 0);
         s.ex_md_div       = ($urandom_range(0, 1) == 1);
         if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 80);
         if (burst > 0) begin
            s.mem_req   = 1'b1;
            s.mem_ready = 1'b0;
            burst--;
         end else begin
            s.mem_req   = ($urandom_range(0, 1) == 1);
            s.mem_ready = ($urandom_range(0, 3) != 0);
         end
         s.rst = ($urandom_range(0, 499) == 0);
         apply_stimulus(s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
